// File: rtl/guess_judge_if.sv
// Guess/target/feedback bundle between the input block, the judge and the display logic.
// master drives the guess, target and game control; slave returns the judgement and game status.
interface guess_judge_if;
    logic       confirm;
    logic [3:0] guess_digit_1;
    logic [3:0] guess_digit_2;
    logic [3:0] guess_digit_3;
    logic [3:0] target_digit_1;
    logic [3:0] target_digit_2;
    logic [3:0] target_digit_3;
    logic [1:0] max_digits;
    logic       new_game;
    logic       result_valid;
    logic       result_higher;
    logic       result_lower;
    logic       result_correct;
    logic [3:0] attempts_used;
    logic [3:0] attempts_left;
    logic       busy;
    logic       game_won;
    logic       game_over;

    modport master (
        output confirm, guess_digit_1, guess_digit_2, guess_digit_3,
        output target_digit_1, target_digit_2, target_digit_3, max_digits, new_game,
        input  result_valid, result_higher, result_lower, result_correct,
        input  attempts_used, attempts_left, busy, game_won, game_over
    );

    modport slave (
        input  confirm, guess_digit_1, guess_digit_2, guess_digit_3,
        input  target_digit_1, target_digit_2, target_digit_3, max_digits, new_game,
        output result_valid, result_higher, result_lower, result_correct,
        output attempts_used, attempts_left, busy, game_won, game_over
    );
endinterface

// File: rtl/guess_judge.sv
// Judges a locked-in BCD guess against the target: higher/lower/correct, attempt count, won/lost.
// Result 3 edges after a confirm rise; confirm rises while busy or game over are dropped.
module guess_judge #(
    parameter int MAX_ATTEMPTS = 7
) (
    input  logic          clk,
    input  logic          reset,
    guess_judge_if.slave  bus
);
    typedef enum logic [2:0] {PLAY, CAPTURE, EVAL, WON, LOST} state_t;

    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    state_t      state;
    state_t      state_nxt;
    logic        confirm_q;
    logic        confirm_rise;
    logic [1:0]  eff_digits;
    logic [11:0] guess_q;
    logic [11:0] target_num;
    logic [3:0]  used_q;
    logic [3:0]  used_nxt;
    logic        valid_q;
    logic        higher_q;
    logic        lower_q;
    logic        correct_q;

    // Digits above the active count are zeroed, so a 3-digit concatenation compares
    // hundreds first, then tens, then ones.
    function automatic logic [11:0] mask_num(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [1:0] n);
        mask_num = {(n == 2'd3) ? d3 : 4'd0, (n >= 2'd2) ? d2 : 4'd0, d1};
    endfunction

    assign confirm_rise = bus.confirm & ~confirm_q;
    assign eff_digits   = (bus.max_digits == 2'd0) ? 2'd1 : bus.max_digits;
    assign target_num   = mask_num(bus.target_digit_3, bus.target_digit_2,
                                   bus.target_digit_1, eff_digits);
    assign used_nxt     = (used_q == MAX_A) ? MAX_A : used_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PLAY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.new_game) begin
            state_nxt = PLAY;
        end else begin
            case (state)
                PLAY:    if (confirm_rise) state_nxt = CAPTURE;
                CAPTURE: state_nxt = EVAL;
                EVAL: begin
                    if (guess_q == target_num)   state_nxt = WON;
                    else if (used_nxt == MAX_A)  state_nxt = LOST;
                    else                         state_nxt = PLAY;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state == CAPTURE) || (state == EVAL);
        bus.game_won  = (state == WON);
        bus.game_over = (state == WON) || (state == LOST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            confirm_q <= 1'b0;
            guess_q   <= 12'd0;
            used_q    <= 4'd0;
            valid_q   <= 1'b0;
            higher_q  <= 1'b0;
            lower_q   <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            confirm_q <= bus.confirm;
            valid_q   <= 1'b0;
            if (bus.new_game) begin
                used_q    <= 4'd0;
                higher_q  <= 1'b0;
                lower_q   <= 1'b0;
                correct_q <= 1'b0;
            end else if (state == CAPTURE) begin
                guess_q <= mask_num(bus.guess_digit_3, bus.guess_digit_2,
                                    bus.guess_digit_1, eff_digits);
            end else if (state == EVAL) begin
                valid_q   <= 1'b1;
                higher_q  <= target_num > guess_q;
                lower_q   <= target_num < guess_q;
                correct_q <= target_num == guess_q;
                used_q    <= used_nxt;
            end
        end
    end

    assign bus.result_valid   = valid_q;
    assign bus.result_higher  = higher_q;
    assign bus.result_lower   = lower_q;
    assign bus.result_correct = correct_q;
    assign bus.attempts_used  = used_q;
    assign bus.attempts_left  = MAX_A - used_q;
endmodule

// File: tb/tb_guess_judge.sv
// Directed bench for guess_judge: one 7-attempt instance and one 3-attempt instance.
module tb_guess_judge;
    logic clk = 1'b0;
    logic reset;
    int   pass  = 0;
    int   total = 0;

    always #5 clk = ~clk;

    guess_judge_if bus ();
    guess_judge_if bus3 ();

    guess_judge #(.MAX_ATTEMPTS(7)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    guess_judge #(.MAX_ATTEMPTS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    task automatic set_target(input bit sel, input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [1:0] md);
        if (sel) begin
            bus3.target_digit_3 = d3; bus3.target_digit_2 = d2; bus3.target_digit_1 = d1;
            bus3.max_digits = md;
        end else begin
            bus.target_digit_3 = d3; bus.target_digit_2 = d2; bus.target_digit_1 = d1;
            bus.max_digits = md;
        end
    endtask

    // Presents a guess with a confirm rise and watches 8 edges for result pulses.
    task automatic guess(input bit sel, input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, output int lat, output int pulses);
        @(negedge clk);
        if (sel) begin
            bus3.guess_digit_3 = d3; bus3.guess_digit_2 = d2; bus3.guess_digit_1 = d1;
            bus3.confirm = 1'b1;
        end else begin
            bus.guess_digit_3 = d3; bus.guess_digit_2 = d2; bus.guess_digit_1 = d1;
            bus.confirm = 1'b1;
        end
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (sel ? bus3.result_valid : bus.result_valid) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        @(negedge clk);
        bus.confirm = 1'b0;
        bus3.confirm = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.attempts_used !== 4'd0) $display("FAIL reset_used got %0d want 0", bus.attempts_used); else pass++;
        total++; if (bus.attempts_left !== 4'd7) $display("FAIL reset_left got %0d want 7", bus.attempts_left); else pass++;
        total++; if (bus3.attempts_left !== 4'd3) $display("FAIL reset_left3 got %0d want 3", bus3.attempts_left); else pass++;
        total++; if ({bus.result_valid, bus.result_higher, bus.result_lower, bus.result_correct} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {bus.result_valid, bus.result_higher, bus.result_lower, bus.result_correct}); else pass++;
        total++; if ({bus.busy, bus.game_won, bus.game_over} !== 3'b0)
            $display("FAIL reset_status got %b want 000", {bus.busy, bus.game_won, bus.game_over}); else pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_higher();
        int lat, pulses;
        set_target(0, 4'd4, 4'd2, 4'd7, 2'd3);
        guess(0, 4'd3, 4'd0, 4'd0, lat, pulses);
        total++; if (lat !== 3) $display("FAIL higher_latency got %0d want 3", lat); else pass++;
        total++; if (pulses !== 1) $display("FAIL higher_pulses got %0d want 1", pulses); else pass++;
        total++; if ({bus.result_higher, bus.result_lower, bus.result_correct} !== 3'b100)
            $display("FAIL higher_flags got %b want 100", {bus.result_higher, bus.result_lower, bus.result_correct}); else pass++;
        total++; if (bus.attempts_used !== 4'd1) $display("FAIL higher_used got %0d want 1", bus.attempts_used); else pass++;
        total++; if (bus.attempts_left !== 4'd6) $display("FAIL higher_left got %0d want 6", bus.attempts_left); else pass++;
    endtask

    task automatic test_lower_correct();
        int lat, pulses;
        pulse_new_game();
        guess(0, 4'd5, 4'd0, 4'd0, lat, pulses);
        total++; if ({bus.result_higher, bus.result_lower, bus.result_correct} !== 3'b010)
            $display("FAIL lower_flags got %b want 010", {bus.result_higher, bus.result_lower, bus.result_correct}); else pass++;
        guess(0, 4'd4, 4'd2, 4'd7, lat, pulses);
        total++; if ({bus.result_higher, bus.result_lower, bus.result_correct} !== 3'b001)
            $display("FAIL correct_flags got %b want 001", {bus.result_higher, bus.result_lower, bus.result_correct}); else pass++;
        total++; if ({bus.game_won, bus.game_over} !== 2'b11)
            $display("FAIL won_status got %b want 11", {bus.game_won, bus.game_over}); else pass++;
        guess(0, 4'd1, 4'd1, 4'd1, lat, pulses);
        total++; if (pulses !== 0) $display("FAIL won_ignores_confirm got %0d pulses want 0", pulses); else pass++;
        total++; if (bus.attempts_used !== 4'd2) $display("FAIL won_used got %0d want 2", bus.attempts_used); else pass++;
    endtask

    task automatic test_lost();
        int lat, pulses;
        set_target(1, 4'd0, 4'd5, 4'd0, 2'd3);
        guess(1, 4'd0, 4'd1, 4'd0, lat, pulses);
        total++; if ({bus3.result_higher, bus3.result_lower} !== 2'b10)
            $display("FAIL lost_g1 got %b want 10", {bus3.result_higher, bus3.result_lower}); else pass++;
        guess(1, 4'd0, 4'd9, 4'd0, lat, pulses);
        total++; if ({bus3.result_higher, bus3.result_lower} !== 2'b01)
            $display("FAIL lost_g2 got %b want 01", {bus3.result_higher, bus3.result_lower}); else pass++;
        total++; if (bus3.game_over !== 1'b0) $display("FAIL lost_early_over got %b want 0", bus3.game_over); else pass++;
        guess(1, 4'd0, 4'd4, 4'd9, lat, pulses);
        total++; if (lat !== 3) $display("FAIL lost_g3_latency got %0d want 3", lat); else pass++;
        total++; if ({bus3.game_over, bus3.game_won} !== 2'b10)
            $display("FAIL lost_status got %b want 10", {bus3.game_over, bus3.game_won}); else pass++;
        total++; if (bus3.attempts_used !== 4'd3) $display("FAIL lost_used got %0d want 3", bus3.attempts_used); else pass++;
        total++; if (bus3.attempts_left !== 4'd0) $display("FAIL lost_left got %0d want 0", bus3.attempts_left); else pass++;
        guess(1, 4'd0, 4'd5, 4'd0, lat, pulses);
        total++; if (pulses !== 0 || bus3.attempts_used !== 4'd3)
            $display("FAIL lost_ignores_confirm got %0d pulses used %0d want 0 pulses used 3", pulses, bus3.attempts_used); else pass++;
    endtask

    task automatic test_mask();
        int lat, pulses;
        pulse_new_game();
        set_target(0, 4'd9, 4'd9, 4'd4, 2'd1);
        guess(0, 4'd1, 4'd1, 4'd4, lat, pulses);
        total++; if (bus.result_correct !== 1'b1 || lat !== 3)
            $display("FAIL mask_md1 got correct %b lat %0d want 1 lat 3", bus.result_correct, lat); else pass++;
        pulse_new_game();
        set_target(0, 4'd9, 4'd9, 4'd4, 2'd0);
        guess(0, 4'd1, 4'd1, 4'd4, lat, pulses);
        total++; if (bus.result_correct !== 1'b1 || bus.game_won !== 1'b1)
            $display("FAIL mask_md0 got correct %b won %b want 1 1", bus.result_correct, bus.game_won); else pass++;
    endtask

    task automatic test_held();
        int pulses;
        pulse_new_game();
        set_target(0, 4'd4, 4'd2, 4'd7, 2'd3);
        @(negedge clk);
        bus.guess_digit_3 = 4'd1; bus.guess_digit_2 = 4'd0; bus.guess_digit_1 = 4'd0;
        bus.confirm = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.result_valid) pulses++;
        end
        total++; if (pulses !== 1) $display("FAIL held_pulses got %0d want 1", pulses); else pass++;
        total++; if (bus.attempts_used !== 4'd1) $display("FAIL held_used got %0d want 1", bus.attempts_used); else pass++;
        @(negedge clk); bus.confirm = 1'b0;
        @(negedge clk); bus.confirm = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b1) $display("FAIL busy_capture got %b want 1", bus.busy); else pass++;
        @(negedge clk); bus.confirm = 1'b0;
        @(negedge clk); bus.confirm = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.result_valid) pulses++;
        end
        @(negedge clk); bus.confirm = 1'b0;
        total++; if (pulses !== 1) $display("FAIL busy_drop_pulses got %0d want 1", pulses); else pass++;
        total++; if (bus.attempts_used !== 4'd2) $display("FAIL busy_drop_used got %0d want 2", bus.attempts_used); else pass++;
    endtask

    task automatic test_new_game();
        int lat, pulses;
        @(negedge clk);
        bus.confirm = 1'b1;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.result_valid) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL ng_confirm_pulses got %0d want 0", pulses); else pass++;
        total++; if ({bus.attempts_used, bus.result_higher, bus.busy} !== 6'b0)
            $display("FAIL ng_confirm_state got used %0d higher %b busy %b want 0 0 0", bus.attempts_used, bus.result_higher, bus.busy); else pass++;
        @(negedge clk); bus.confirm = 1'b0;
        guess(0, 4'd1, 4'd0, 4'd0, lat, pulses);
        @(negedge clk); bus.confirm = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); bus.new_game = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.result_valid !== 1'b0) $display("FAIL ng_eval_valid got %b want 0", bus.result_valid); else pass++;
        total++; if ({bus.attempts_used, bus.result_higher, bus.busy} !== 6'b0)
            $display("FAIL ng_eval_state got used %0d higher %b busy %b want 0 0 0", bus.attempts_used, bus.result_higher, bus.busy); else pass++;
        @(negedge clk); bus.new_game = 1'b0; bus.confirm = 1'b0;
    endtask

    task automatic test_reset_mid_eval();
        int lat, pulses;
        guess(0, 4'd1, 4'd0, 4'd0, lat, pulses);
        @(negedge clk); bus.confirm = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        total++; if (bus.attempts_used !== 4'd0 || bus.attempts_left !== 4'd7)
            $display("FAIL rst_eval_counts got used %0d left %0d want 0 7", bus.attempts_used, bus.attempts_left); else pass++;
        total++; if ({bus.result_higher, bus.busy, bus.result_valid} !== 3'b0)
            $display("FAIL rst_eval_flags got %b want 000", {bus.result_higher, bus.busy, bus.result_valid}); else pass++;
        @(negedge clk); reset = 1'b0; bus.confirm = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.confirm = 1'b0; bus.new_game = 1'b0; bus.max_digits = 2'd3;
        bus.guess_digit_1 = 4'd0; bus.guess_digit_2 = 4'd0; bus.guess_digit_3 = 4'd0;
        bus.target_digit_1 = 4'd0; bus.target_digit_2 = 4'd0; bus.target_digit_3 = 4'd0;
        bus3.confirm = 1'b0; bus3.new_game = 1'b0; bus3.max_digits = 2'd3;
        bus3.guess_digit_1 = 4'd0; bus3.guess_digit_2 = 4'd0; bus3.guess_digit_3 = 4'd0;
        bus3.target_digit_1 = 4'd0; bus3.target_digit_2 = 4'd0; bus3.target_digit_3 = 4'd0;
        test_reset();
        test_higher();
        test_lower_correct();
        test_lost();
        test_mask();
        test_held();
        test_new_game();
        test_reset_mid_eval();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/guess_judge.md
# guess_judge

Game-side evaluator that pairs with the player input block. It takes the locked-in guess digits, compares them against the secret target under the current difficulty, and produces higher/lower/correct feedback. It also counts attempts and declares the game won or lost. It sits between the input block (guess digits plus the confirm button) and the display/LED feedback logic.

## Interface
- MAX_ATTEMPTS, 7, number of guesses allowed per game; legal range 1..15.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state below.
- confirm  input  1  the same confirm button level that locks the guess into the input block; the rising edge is detected internally.
- guess_digit_1, guess_digit_2, guess_digit_3  input  4 each  locked-in guess, BCD; digit_1 = ones, digit_3 = hundreds.
- target_digit_1, target_digit_2, target_digit_3  input  4 each  secret number, BCD, same digit order; must be stable during a game.
- max_digits  input  2  active digit count (difficulty); a value of 0 is treated as 1.
- new_game  input  1  single-cycle pulse that restarts the game.
- result_valid  output  1  one-cycle pulse when a guess has been judged.
- result_higher  output  1  target > guess (guess too low); held.
- result_lower  output  1  target < guess (guess too high); held.
- result_correct  output  1  target == guess; held.
- attempts_used  output  4  guesses judged this game.
- attempts_left  output  4  MAX_ATTEMPTS - attempts_used.
- busy  output  1  high in CAPTURE and EVAL.
- game_won  output  1  high in WON.
- game_over  output  1  high in WON or LOST.

## Operation
- Reset: state PLAY, all flags 0, attempts_used 0, attempts_left MAX_ATTEMPTS, confirm edge register 0.
- Edge detect: confirm_rise = confirm & ~confirm_q, where confirm_q is confirm registered each cycle. Holding the button counts as one guess.
- FSM states: PLAY, CAPTURE, EVAL, WON, LOST.
  - PLAY: on confirm_rise, go to CAPTURE.
  - CAPTURE: register the guess digits, masked by the active digit count; go to EVAL.
  - EVAL: compare, update flags and counters, pulse result_valid.
    - If correct, go to WON.
    - Else, if attempts_used after increment == MAX_ATTEMPTS, go to LOST.
    - Else, go to PLAY.
  - WON / LOST: remain until new_game; confirm is ignored.
- Masking: a digit with index > effective max_digits is forced to 0 on both the guess and target sides before comparison.
- Compare order: hundreds digit first, then tens, then ones; the first unequal digit decides. Raw 4-bit compare, so non-BCD values are not flagged.
- Flags: exactly one of higher/lower/correct is 1 after the first judgement. All three are 0 after reset or new_game.
- attempts_used saturates at MAX_ATTEMPTS and never wraps.
- new_game: from any state, next state is PLAY. It clears flags and counters and clears the confirm edge history to the current confirm level (a held button is not taken as a guess). It has priority over confirm and over an in-flight EVAL.
- A confirm_rise while busy, WON, or LOST is dropped, not queued.

## Timing
- Cycle N: confirm_rise seen in PLAY. The input block updates the guess digits at this edge.
- Cycle N+1: CAPTURE samples guess_digit_* (values now stable). busy = 1.
- Cycle N+2: EVAL registers outputs. Flags, attempts, and game_won/game_over are visible from edge N+3, together with the one-cycle result_valid.
- Latency from confirm rise to result: 3 edges. Throughput: at most one guess per 3 cycles.
- Reset asserted mid-CAPTURE/EVAL aborts the guess with no count.

## Test plan
- Target 4-2-7 (427), max_digits 3, guess 300 → result_higher=1, attempts_used=1, attempts_left=6, result_valid high exactly once, 3 edges after confirm rise.
- Same target, guesses 500 then 427 → lower, then correct. game_won=1, game_over=1; a further confirm gives no result_valid and attempts stay at 2.
- MAX_ATTEMPTS=3, target 050, three wrong guesses 010/090/049 → LOST on the third, game_over=1, game_won=0, attempts_used=3, attempts_left=0.
- max_digits 1, target 9-9-4, guess 1-1-4 → correct, because upper digits are masked. max_digits 0 with the same inputs behaves identically.
- confirm held high 20 cycles → exactly one judgement. confirm pulsed again during busy → dropped; attempts_used increments by 1 only.
- new_game asserted in the same cycle as a confirm rise, and separately during EVAL → state PLAY, all flags 0, attempts_used 0, no result_valid. Async reset mid-EVAL → all outputs at reset values before the next edge.
